// File: rtl/lif_scheduler.sv
//==============================================================================
// Module      : lif_scheduler
// Description : Time-multiplexed leaky integrate-and-fire neuron scheduler.
//               One accumulate/leak/compare datapath is shared by N_NEU
//               neurons. The weights and the membrane potentials are held in
//               internal register arrays.
//               For each timestep, every neuron spends N_IN cycles
//               accumulating weighted input spikes (ACC). It then spends one
//               cycle applying leak, integrating and comparing against the
//               threshold (UPD).
//
// Ports       : clk        - clock, rising edge
//               rstn       - synchronous active-low reset
//               step_i     - start-of-timestep request (accepted in IDLE only)
//               spikes_i   - input spike vector, latched on step acceptance
//               wr_en_i    - weight write strobe (effective in IDLE only)
//               wr_addr_i  - weight index = neuron*N_IN + input
//               wr_data_i  - unsigned weight value
//               busy_o     - high while a timestep is being processed
//               done_o     - one-cycle pulse when a timestep completes
//               spikes_o   - neuron spike vector of last completed timestep
//
// Macros      : DEF_V_SIZE         - default potential/weight width (8)
//               LIF_REFRACTORY_EN  - when defined, a neuron that fired in the
//                                    previous completed timestep has its
//                                    input forced to zero and cannot fire
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef DEF_V_SIZE
`define DEF_V_SIZE 8
`endif

module lif_scheduler #(
    parameter int unsigned  V_SIZE     = `DEF_V_SIZE,
    parameter int unsigned  N_IN       = 3,
    parameter int unsigned  N_NEU      = 3,
    parameter int unsigned  THRESH     = 8,
    parameter int unsigned  LEAK_SHIFT = 1,
    localparam int unsigned c_NW       = N_NEU * N_IN,
    localparam int unsigned c_AW       = (c_NW  > 1) ? $clog2(c_NW)  : 1,
    localparam int unsigned c_IW       = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int unsigned c_NIW      = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              step_i,
    input  logic [N_IN-1:0]   spikes_i,
    input  logic              wr_en_i,
    input  logic [c_AW-1:0]   wr_addr_i,
    input  logic [V_SIZE-1:0] wr_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_NEU-1:0]  spikes_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_UPD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Storage
    logic [V_SIZE-1:0] r_w [c_NW];
    logic [V_SIZE-1:0] r_v [N_NEU];

    // Sequencing and datapath registers
    logic [V_SIZE-1:0] r_acc;
    logic [c_IW-1:0]   r_i;
    logic [c_NIW-1:0]  r_n;
    logic [c_AW-1:0]   r_widx;
    logic [N_IN-1:0]   r_spk_lat;
    logic [N_NEU-1:0]  r_spk_new;
    logic [N_NEU-1:0]  r_spikes;

    // Combinational datapath
    logic              w_last_i;
    logic              w_last_n;
    logic              w_wr_ok;
    logic              w_refr;
    logic              w_fire;
    logic [V_SIZE:0]   w_acc_sum;
    logic [V_SIZE-1:0] w_acc_next;
    logic [V_SIZE-1:0] w_acc_eff;
    logic [V_SIZE-1:0] w_v;
    logic [V_SIZE-1:0] w_leak;
    logic [V_SIZE-1:0] w_vkeep;
    logic [V_SIZE:0]   w_vsum;
    logic [V_SIZE-1:0] w_vnew;
    logic [N_NEU-1:0]  w_spk_all;

    assign w_last_i = (r_i == c_IW'(N_IN - 1));
    assign w_last_n = (r_n == c_NIW'(N_NEU - 1));
    assign w_wr_ok  = wr_en_i && (32'(wr_addr_i) < c_NW);

    //--------------------------------------------------------------------------
    // Accumulate stage: saturating add of the selected weight.
    // The weight pointer runs linearly through the array across all neurons,
    // so no n*N_IN+i multiply is needed.
    //--------------------------------------------------------------------------
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_w[r_widx]};
    assign w_acc_next = w_acc_sum[V_SIZE] ? {V_SIZE{1'b1}} : w_acc_sum[V_SIZE-1:0];

    //--------------------------------------------------------------------------
    // Update stage: leak, integrate, saturate, compare
    //--------------------------------------------------------------------------
    assign w_v = r_v[r_n];

    // A zero shift means no leak rather than subtracting the whole potential.
    generate
        if (LEAK_SHIFT == 0) begin : g_no_leak
            assign w_leak = '0;
        end else begin : g_leak
            assign w_leak = w_v >> LEAK_SHIFT;
        end
    endgenerate

`ifdef LIF_REFRACTORY_EN
    logic [N_NEU-1:0] r_refr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_refr <= '0;
        end else if (r_state == S_UPD && w_last_n) begin
            r_refr <= w_spk_all;
        end
    end

    assign w_refr = r_refr[r_n];
`else
    assign w_refr = 1'b0;
`endif

    assign w_acc_eff = w_refr ? '0 : r_acc;
    // w_leak <= w_v always, so this subtraction cannot underflow.
    assign w_vkeep   = w_v - w_leak;
    assign w_vsum    = {1'b0, w_vkeep} + {1'b0, w_acc_eff};
    assign w_vnew    = w_vsum[V_SIZE] ? {V_SIZE{1'b1}} : w_vsum[V_SIZE-1:0];
    assign w_fire    = !w_refr && (32'(w_vnew) >= THRESH);

    // New spike vector including the neuron currently in UPD. It is
    // published on the last UPD so spikes_o is already valid during DONE.
    always_comb begin
        w_spk_all      = r_spk_new;
        w_spk_all[r_n] = w_fire;
    end

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next state and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (step_i) begin
                    w_next = S_ACC;
                end
            end
            S_ACC: begin
                busy_o = 1'b1;
                if (w_last_i) begin
                    w_next = S_UPD;
                end
            end
            S_UPD: begin
                busy_o = 1'b1;
                w_next = w_last_n ? S_DONE : S_ACC;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and storage
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < int'(c_NW); k++) begin
                r_w[k] <= '0;
            end
            for (int k = 0; k < int'(N_NEU); k++) begin
                r_v[k] <= '0;
            end
            r_acc     <= '0;
            r_i       <= '0;
            r_n       <= '0;
            r_widx    <= '0;
            r_spk_lat <= '0;
            r_spk_new <= '0;
            r_spikes  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A write in the same cycle as an accepted step lands
                    // before the first ACC read, so that timestep uses it.
                    if (w_wr_ok) begin
                        r_w[wr_addr_i] <= wr_data_i;
                    end
                    if (step_i) begin
                        r_spk_lat <= spikes_i;
                        r_acc     <= '0;
                        r_i       <= '0;
                        r_n       <= '0;
                        r_widx    <= '0;
                        r_spk_new <= '0;
                    end
                end
                S_ACC: begin
                    if (r_spk_lat[r_i]) begin
                        r_acc <= w_acc_next;
                    end
                    r_i    <= w_last_i ? '0 : r_i + 1'b1;
                    r_widx <= r_widx + 1'b1;
                end
                S_UPD: begin
                    r_v[r_n]  <= w_fire ? '0 : w_vnew;
                    r_spk_new <= w_spk_all;
                    r_acc     <= '0;
                    if (w_last_n) begin
                        r_spikes <= w_spk_all;
                    end else begin
                        r_n <= r_n + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign spikes_o = r_spikes;

endmodule

`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none

module tb_lif_scheduler;

    localparam int V_MAX = 255;
    localparam int NI    = 3;
    localparam int NN    = 3;
    localparam int NW    = 9;
    localparam int TH    = 8;
    localparam int LS    = 1;
    localparam int LAT   = 12;   // edges after the accepting edge until done_o

    logic       clk = 1'b0;
    logic       rstn;
    logic       step_i;
    logic [2:0] spikes_i;
    logic       wr_en_i;
    logic [3:0] wr_addr_i;
    logic [7:0] wr_data_i;
    logic       busy_o;
    logic       done_o;
    logic [2:0] spikes_o;

    always #5 clk = ~clk;

    lif_scheduler dut (
        .clk       (clk),
        .rstn      (rstn),
        .step_i    (step_i),
        .spikes_i  (spikes_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .spikes_o  (spikes_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         mw [NW];
    int         mv [NN];
    logic [2:0] mspk;
    logic [2:0] mrefr;

    typedef struct {
        logic [2:0] spk;
        logic [2:0] exp_plain;
        logic [2:0] exp_refr;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NW; k++) mw[k] = 0;
        for (int k = 0; k < NN; k++) mv[k] = 0;
        mspk  = '0;
        mrefr = '0;
    endfunction

    function automatic void model_step(input logic [2:0] spk);
        logic [2:0] nsp;
        nsp = '0;
        for (int n = 0; n < NN; n++) begin
            int acc;
            int vn;
            bit refr;
            refr = mrefr[n];
            acc  = 0;
            for (int i = 0; i < NI; i++) if (spk[i]) acc += mw[n*NI + i];
            if (acc > V_MAX) acc = V_MAX;
            if (refr) acc = 0;
            vn = mv[n] - ((LS == 0) ? 0 : (mv[n] >> LS)) + acc;
            if (vn > V_MAX) vn = V_MAX;
            if (!refr && vn >= TH) begin
                nsp[n] = 1'b1;
                mv[n]  = 0;
            end else begin
                mv[n] = vn;
            end
        end
        mspk = nsp;
`ifdef LIF_REFRACTORY_EN
        mrefr = nsp;
`endif
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_spikes_o"}, int'(spikes_o), int'(mspk));
        for (int n = 0; n < NN; n++)
            chk($sformatf("%s_v%0d", tag, n), int'(dut.r_v[n]), mv[n]);
        for (int k = 0; k < NW; k++)
            chk($sformatf("%s_w%0d", tag, k), int'(dut.r_w[k]), mw[k]);
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        step_i  = 1'b0;
        wr_en_i = 1'b0;
        tick();
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic write_w(input int addr, input int data);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'(addr);
        wr_data_i = 8'(data);
        tick();
        wr_en_i = 1'b0;
        if (addr < NW) mw[addr] = data;
    endtask

    // Runs one timestep. inj >= 0 pulses step_i plus a write to weight 0
    // that many edges after acceptance. wr_now writes together with step.
    task automatic run_step(input logic [2:0] spk, input int inj,
                            input bit wr_now, input int waddr, input int wdata);
        int cnt;
        bit seen;
        step_i   = 1'b1;
        spikes_i = spk;
        if (wr_now) begin
            wr_en_i   = 1'b1;
            wr_addr_i = 4'(waddr);
            wr_data_i = 8'(wdata);
            if (waddr < NW) mw[waddr] = wdata;
        end
        tick();
        step_i   = 1'b0;
        wr_en_i  = 1'b0;
        spikes_i = 3'($urandom);
        model_step(spk);
        chk("busy_after_accept", int'(busy_o), 1);
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 40) begin
            if (cnt == inj) begin
                step_i    = 1'b1;
                wr_en_i   = 1'b1;
                wr_addr_i = 4'd0;
                wr_data_i = 8'd7;
            end
            tick();
            cnt++;
            step_i  = 1'b0;
            wr_en_i = 1'b0;
            if (done_o) seen = 1;
        end
        chk("done_latency", cnt, LAT);
        chk("busy_in_done", int'(busy_o), 0);
        check_state("post_step");
        tick();
        chk("done_one_cycle", int'(done_o), 0);
        chk("idle_busy", int'(busy_o), 0);
        chk("spikes_hold", int'(spikes_o), int'(mspk));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        logic [2:0] exp40 [3];

        // n0={3,3,2}, n1={4,0,0}, n2={255,255,255}; expected values by hand
        vecs[0] = '{spk: 3'b111, exp_plain: 3'b101, exp_refr: 3'b101};
        vecs[1] = '{spk: 3'b001, exp_plain: 3'b100, exp_refr: 3'b000};
        vecs[2] = '{spk: 3'b000, exp_plain: 3'b000, exp_refr: 3'b000};
        vecs[3] = '{spk: 3'b111, exp_plain: 3'b101, exp_refr: 3'b101};
        vecs[4] = '{spk: 3'b110, exp_plain: 3'b100, exp_refr: 3'b000};

        rstn      = 1'b0;
        step_i    = 1'b0;
        spikes_i  = '0;
        wr_en_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        tick();
        tick();
        rstn = 1'b1;
        model_reset();

        // Reset state
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        check_state("rst");

        // Weight setup and out-of-range writes
        write_w(0, 3); write_w(1, 3); write_w(2, 2);
        write_w(3, 4);
        write_w(6, 255); write_w(7, 255); write_w(8, 255);
        for (int a = 9; a < 16; a++) write_w(a, 99);
        check_state("setup");

        // Table-driven steps
        for (int r = 0; r < 5; r++) begin
            run_step(vecs[r].spk, -1, 0, 0, 0);
`ifdef LIF_REFRACTORY_EN
            chk($sformatf("tbl_row%0d", r), int'(spikes_o), int'(vecs[r].exp_refr));
`else
            chk($sformatf("tbl_row%0d", r), int'(spikes_o), int'(vecs[r].exp_plain));
`endif
        end

        // Step and write while busy are dropped
        run_step(3'b111, 4, 0, 0, 0);
        chk("busy_wr_dropped_w0", int'(dut.r_w[0]), 3);

        // Reset in the middle of a timestep
        step_i   = 1'b1;
        spikes_i = 3'b111;
        tick();
        step_i = 1'b0;
        repeat (5) tick();
        chk("busy_mid_step", int'(busy_o), 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        model_reset();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done_o) seen = 1;
        end
        chk("abort_no_done", int'(seen), 0);
        chk("abort_busy", int'(busy_o), 0);
        check_state("abort");

        // Single neuron firing, then refractory behaviour over three steps
        write_w(0, 3); write_w(1, 3); write_w(2, 2);
`ifdef LIF_REFRACTORY_EN
        exp40[0] = 3'b001; exp40[1] = 3'b000; exp40[2] = 3'b001;
`else
        exp40[0] = 3'b001; exp40[1] = 3'b001; exp40[2] = 3'b001;
`endif
        for (int s = 0; s < 3; s++) begin
            run_step(3'b111, -1, 0, 0, 0);
            chk($sformatf("seq3_step%0d", s), int'(spikes_o), int'(exp40[s]));
        end
        chk("seq3_v0", int'(dut.r_v[0]), 0);

        // Leak without firing
        do_reset();
        write_w(3, 4);
        run_step(3'b001, -1, 0, 0, 0);
        chk("leak_v1_a", int'(dut.r_v[1]), 4);
        chk("leak_spk1_a", int'(spikes_o[1]), 0);
        run_step(3'b000, -1, 0, 0, 0);
        chk("leak_v1_b", int'(dut.r_v[1]), 2);
        chk("leak_spk1_b", int'(spikes_o[1]), 0);

        // Write together with step is used by that step
        do_reset();
        run_step(3'b001, -1, 1, 0, 9);
        chk("wr_with_step_spk0", int'(spikes_o[0]), 1);

        // Randomized against the reference model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++)
                write_w($urandom_range(0, 15),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                                    : $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0)
                run_step(3'($urandom), -1, 1, $urandom_range(0, 15), $urandom_range(0, 6));
            else
                run_step(3'($urandom), -1, 0, 0, 0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter V_SIZE, default `DEF_V_SIZE, membrane potential and weight width.
REQ-002 SHALL have parameter N_IN, default 3, number of input spike lines.
REQ-003 SHALL have parameter N_NEU, default 3, number of time-multiplexed neurons.
REQ-004 SHALL have parameter THRESH, default 8, firing threshold (unsigned).
REQ-005 SHALL have parameter LEAK_SHIFT, default 1, leak right-shift amount.
REQ-006 SHALL have clk, input, 1, the single clock; all logic rising-edge.
REQ-007 SHALL have rstn, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have step_i, input, 1, start-of-timestep request.
REQ-009 SHALL have spikes_i, input, N_IN, input spike vector, sampled on step acceptance.
REQ-010 SHALL have wr_en_i, input, 1, weight write strobe.
REQ-011 SHALL have wr_addr_i, input, clog2(N_NEU*N_IN), weight index = neuron*N_IN + input.
REQ-012 SHALL have wr_data_i, input, V_SIZE, unsigned weight value.
REQ-013 SHALL have busy_o, output, 1, high while a timestep is being processed.
REQ-014 SHALL have done_o, output, 1, one-cycle pulse at timestep completion.
REQ-015 SHALL have spikes_o, output, N_NEU, neuron spike vector of the last completed timestep.

Function
REQ-016 SHALL share one accumulate/leak/compare datapath across N_NEU neurons; potentials and weights held in internal register arrays.
REQ-017 FSM states SHALL be IDLE, ACC, UPD, DONE.
REQ-018 IDLE: step_i high at an edge SHALL latch spikes_i, clear neuron index n and input index i, enter ACC.
REQ-019 ACC: one cycle per input i=0..N_IN-1, SHALL add weight[n*N_IN+i] to accumulator when latched spike i is 1; after i=N_IN-1 go to UPD.
REQ-020 Accumulator SHALL saturate at 2^V_SIZE-1; cleared at entry to each neuron's ACC.
REQ-021 UPD: v_new = sat(v - (v >> LEAK_SHIFT) + acc); LEAK_SHIFT=0 yields leaked term 0.
REQ-022 UPD: if v_new >= THRESH, neuron spike bit SHALL be 1 and v stored as 0; else spike bit 0 and v_new stored.
REQ-023 UPD SHALL go to ACC for n+1, or to DONE when n=N_NEU-1.
REQ-024 DONE: done_o=1 for exactly one cycle, spikes_o updated with all new spike bits, then IDLE.
REQ-025 Latency: step accepted at edge 0 -> done_o high in cycle N_NEU*(N_IN+1)+1 (13 for defaults).
REQ-026 busy_o SHALL be 1 in ACC and UPD, 0 in IDLE and DONE.
REQ-027 spikes_o SHALL hold its value between DONE cycles.
REQ-028 step_i outside IDLE SHALL be ignored (not queued).
REQ-029 Weight writes SHALL take effect only in IDLE; writes in other states dropped; addresses >= N_NEU*N_IN ignored.
REQ-030 Simultaneous write and step in IDLE: write SHALL commit and be used by that timestep.

Reset
REQ-031 rstn low at an edge SHALL set state IDLE, all potentials 0, all weights 0, spikes_o 0, busy_o 0, done_o 0, refractory flags 0.
REQ-032 Reset mid-timestep SHALL abort with no done_o pulse.

Configuration
REQ-033 Macro LIF_REFRACTORY_EN defined: a neuron that spiked in the previous completed timestep SHALL have acc forced 0 and SHALL NOT spike in the current timestep (one-timestep refractory).
REQ-034 Macro LIF_REFRACTORY_EN undefined: no refractory state exists; neurons may fire every timestep.

Verification
REQ-035 Weights n0={3,3,2}, spikes_i=3'b111, step -> done_o in cycle 13, spikes_o[0]=1, v0=0.
REQ-036 n1 weight[0]=4 others 0, step spikes 3'b001 -> v1=4, no spike; step spikes 3'b000 -> v1=2, spikes_o[1]=0.
REQ-037 n2 weights all 255, spikes 3'b111 -> accumulator saturates 255, spikes_o[2]=1, v2=0.
REQ-038 step_i and wr_en_i(addr 0, data 7) pulsed at cycle 5 of busy -> no restart, weight[0] unchanged, done_o still in cycle 13.
REQ-039 rstn low at cycle 6 of timestep -> no done_o, busy_o=0, spikes_o=0, all weights/potentials 0.
REQ-040 REQ-035 setup, three consecutive steps -> with LIF_REFRACTORY_EN spikes_o[0]=1,0,1; without it 1,1,1.
